// File: rtl/mips_pkg.sv
// Shared constants and types for the single-cycle MIPS core.
// Opcode/function codes, next-PC select encoding, run/halt states.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FUNC_JR      = 6'h08;
   localparam logic [5:0] FUNC_SYSCALL = 6'h0c;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] HALT_CODE_DEF = 32'd10;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } run_state_e;

   // Word offset of a branch, sign-extended to a byte displacement.
   function automatic logic [31:0] br_disp(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory bus plus the decoder-facing field slices.
// master = fetch stage, slave = memory / decoder side.
interface pc_fetch_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [5:0]  op;
   logic [5:0]  func;
   logic [15:0] imm16;

   modport master (
      output imem_addr,
      output op,
      output func,
      output imm16,
      input  imem_data
   );

   modport slave (
      input  imem_addr,
      input  op,
      input  func,
      input  imm16,
      output imem_data
   );

endinterface

// File: rtl/pc_fetch_go_sync.sv
// Two-flop synchronizer for the resume button plus rising-edge detect.
// rise is high for one cycle, two edges after go_async first samples high.
module go_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic go_async,
   output logic rise
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;

   // Shift the button through the sync chain and remember last value.
   always_comb begin
      s1_d   = go_async;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   // Sync and edge-history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/pc_fetch.sv
// Fetch / next-PC stage of the single-cycle MIPS core.
// Owns the PC, run/halt FSM for SYSCALL, and the display counters.
module pc_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] HALT_CODE = HALT_CODE_DEF,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   pc_fetch_if.master       imem,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   input  logic             beq,
   input  logic             bne,
   input  logic             bgtz,
   input  logic             jmp,
   input  logic             jr,
   input  logic             syscall,
   input  logic [31:0]      rs_val,
   input  logic             alu_zero,
   input  logic [31:0]      v0_val,
   input  logic             go,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] jump_cnt,
   output logic [CNT_W-1:0] br_taken_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      pc_q, pc_d;
   run_state_e       state_q, state_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] jmp_q, jmp_d;
   logic [CNT_W-1:0] brc_q, brc_d;

   logic [31:0] seq_pc;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] next_pc;
   npc_sel_e    npc_sel;
   logic        bgtz_ok;
   logic        take_br;
   logic        halt_req;
   logic        go_rise;
   logic        halted_w;

   go_sync u_go_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .go_async (go),
      .rise     (go_rise)
   );

   // Fetch address and zero-latency field slices for the decoder.
   assign imem.imem_addr = pc_q;
   assign imem.op        = imem.imem_data[31:26];
   assign imem.func      = imem.imem_data[5:0];
   assign imem.imm16     = imem.imem_data[15:0];

   // Candidate targets and branch resolution.
   always_comb begin
      seq_pc   = pc_q + 32'd4;
      br_tgt   = seq_pc + br_disp(imem.imem_data[15:0]);
      j_tgt    = {seq_pc[31:28], imem.imem_data[25:0], 2'b00};
      bgtz_ok  = $signed(rs_val) > $signed(32'sd0);
      take_br  = (beq & alu_zero)
               | (bne & ~alu_zero)
               | (bgtz & bgtz_ok);
      halt_req = syscall & (v0_val == HALT_CODE);
   end

   // Next-PC select: JR beats J (decoder raises both for JR).
   always_comb begin
      npc_sel = NPC_SEQ;
      if (jr)
         npc_sel = NPC_JR;
      else if (jmp)
         npc_sel = NPC_J;
      else if (take_br)
         npc_sel = NPC_BR;
   end

   // Next-PC mux.
   always_comb begin
      next_pc = seq_pc;
      unique case (npc_sel)
         NPC_JR:  next_pc = rs_val;
         NPC_J:   next_pc = j_tgt;
         NPC_BR:  next_pc = br_tgt;
         NPC_SEQ: next_pc = seq_pc;
         default: next_pc = seq_pc;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_RUN;
      else
         state_q <= state_d;
   end

   // FSM next state: halting SYSCALL parks, go pulse resumes.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN:  if (halt_req) state_d = ST_HALT;
         ST_HALT: if (go_rise)  state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // FSM outputs.
   always_comb begin
      halted_w = (state_q == ST_HALT);
   end

   // PC and counter updates; everything freezes while halted.
   always_comb begin
      pc_d  = pc_q;
      cyc_d = cyc_q;
      jmp_d = jmp_q;
      brc_d = brc_q;
      if (state_q == ST_RUN) begin
         cyc_d = cyc_q + CNT_ONE;
         if (jmp)
            jmp_d = jmp_q + CNT_ONE;
         if (take_br & ~jmp)
            brc_d = brc_q + CNT_ONE;
         if (!halt_req)
            pc_d = next_pc;
      end else if (go_rise) begin
         pc_d = seq_pc;
      end
   end

   // PC and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         cyc_q <= '0;
         jmp_q <= '0;
         brc_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cyc_q <= cyc_d;
         jmp_q <= jmp_d;
         brc_q <= brc_d;
      end
   end

   assign pc           = pc_q;
   assign pc_plus4     = seq_pc;
   assign halted       = halted_w;
   assign cycle_cnt    = cyc_q;
   assign jump_cnt     = jmp_q;
   assign br_taken_cnt = brc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: next-PC, counters, halt/resume, reset.
// Expected values are hand-computed per step.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc, pc_plus4;
   logic        beq, bne, bgtz, jmp, jr, syscall;
   logic [31:0] rs_val;
   logic        alu_zero;
   logic [31:0] v0_val;
   logic        go;
   logic        halted;
   logic [31:0] cycle_cnt, jump_cnt, br_taken_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   pc_fetch_if imem ();

   pc_fetch #(
      .RESET_PC  (32'h0000_0000),
      .HALT_CODE (32'd10),
      .CNT_W     (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (imem),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .beq          (beq),
      .bne          (bne),
      .bgtz         (bgtz),
      .jmp          (jmp),
      .jr           (jr),
      .syscall      (syscall),
      .rs_val       (rs_val),
      .alu_zero     (alu_zero),
      .v0_val       (v0_val),
      .go           (go),
      .halted       (halted),
      .cycle_cnt    (cycle_cnt),
      .jump_cnt     (jump_cnt),
      .br_taken_cnt (br_taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      beq = 0; bne = 0; bgtz = 0; jmp = 0; jr = 0;
      syscall = 0; alu_zero = 0;
      rs_val = 32'h0; v0_val = 32'h0;
      imem.imem_data = 32'h0;
   endtask

   task automatic do_jr(input logic [31:0] tgt);
      clr();
      jmp = 1; jr = 1; rs_val = tgt;
      tick();
   endtask

   task automatic chk_cnt(input string tag,
                          input logic [31:0] c,
                          input logic [31:0] j,
                          input logic [31:0] b);
      chk({tag, ".cyc"}, cycle_cnt, c);
      chk({tag, ".jmp"}, jump_cnt, j);
      chk({tag, ".br"}, br_taken_cnt, b);
   endtask

   initial begin
      rst_n = 0;
      go = 0;
      clr();
      #2;
      chk("rst.pc", pc, 32'h0);
      chk("rst.addr", imem.imem_addr, 32'h0);
      chk("rst.halted", {31'b0, halted}, 32'h0);
      chk_cnt("rst", 0, 0, 0);

      imem.imem_data = 32'h8D2A_FFFE;
      #1;
      chk("slice.op", {26'b0, imem.op}, 32'h23);
      chk("slice.func", {26'b0, imem.func}, 32'h3e);
      chk("slice.imm", {16'b0, imem.imm16}, 32'hfffe);
      clr();

      #9 rst_n = 1;

      tick(); chk("nop1", pc, 32'h4);
      tick(); chk("nop2", pc, 32'h8);
      tick(); chk("nop3", pc, 32'hc);
      chk("nop.addr", imem.imem_addr, 32'hc);
      chk("nop.p4", pc_plus4, 32'h10);
      chk("nop.halted", {31'b0, halted}, 32'h0);
      chk_cnt("nop", 3, 0, 0);

      do_jr(32'h10); chk("jr10", pc, 32'h10);

      clr(); beq = 1; alu_zero = 1; imem.imem_data = 32'h1000_fffe;
      tick(); chk("beq.t", pc, 32'hc);
      chk_cnt("beq.t", 5, 1, 1);

      do_jr(32'h10);
      clr(); beq = 1; alu_zero = 0; imem.imem_data = 32'h1000_fffe;
      tick(); chk("beq.nt", pc, 32'h14);
      chk_cnt("beq.nt", 7, 2, 1);

      clr(); bne = 1; alu_zero = 0; imem.imem_data = 32'h1400_0001;
      tick(); chk("bne.t", pc, 32'h1c);
      chk_cnt("bne.t", 8, 2, 2);

      do_jr(32'h0040_0020);
      clr(); jmp = 1; imem.imem_data = 32'h0810_0000;
      tick(); chk("j", pc, 32'h0040_0000);
      chk_cnt("j", 10, 4, 2);

      clr(); jmp = 1; jr = 1; rs_val = 32'h100;
      imem.imem_data = 32'h0810_0000;
      tick(); chk("jr.pri", pc, 32'h100);
      chk_cnt("jr.pri", 11, 5, 2);

      clr(); jmp = 1; beq = 1; alu_zero = 1;
      imem.imem_data = 32'h0810_0000;
      tick(); chk("j.over.br", pc, 32'h0040_0000);
      chk_cnt("j.over.br", 12, 6, 2);

      clr(); bgtz = 1; rs_val = 32'h8000_0000;
      imem.imem_data = 32'h1c00_0004;
      tick(); chk("bgtz.neg", pc, 32'h0040_0004);
      bgtz = 1; rs_val = 32'h1;
      tick(); chk("bgtz.pos", pc, 32'h0040_0018);
      bgtz = 1; rs_val = 32'h0;
      tick(); chk("bgtz.zero", pc, 32'h0040_001c);
      chk_cnt("bgtz", 15, 6, 3);

      do_jr(32'hffff_fffc);
      clr(); tick(); chk("wrap", pc, 32'h0);
      do_jr(32'h103); chk("jr.unal", pc, 32'h103);
      do_jr(32'h30);
      chk_cnt("pre.halt", 19, 9, 3);

      clr(); syscall = 1; v0_val = 32'd10;
      tick();
      chk("halt.pc", pc, 32'h30);
      chk("halt.h", {31'b0, halted}, 32'h1);
      chk_cnt("halt", 20, 9, 3);

      clr(); jmp = 1; jr = 1; rs_val = 32'h500; beq = 1; alu_zero = 1;
      repeat (3) tick();
      chk("hold.pc", pc, 32'h30);
      chk("hold.h", {31'b0, halted}, 32'h1);
      chk_cnt("hold", 20, 9, 3);

      clr(); go = 1;
      tick(); tick();
      chk("go2.pc", pc, 32'h30);
      chk("go2.h", {31'b0, halted}, 32'h1);
      go = 0;
      tick();
      chk("go3.pc", pc, 32'h34);
      chk("go3.h", {31'b0, halted}, 32'h0);
      chk_cnt("go3", 20, 9, 3);

      clr(); syscall = 1; v0_val = 32'd1;
      tick();
      chk("sys1.pc", pc, 32'h38);
      chk("sys1.h", {31'b0, halted}, 32'h0);
      chk("sys1.cyc", cycle_cnt, 32'd21);

      clr(); go = 1;
      repeat (3) tick();
      chk("gorun.pc", pc, 32'h44);
      chk("gorun.h", {31'b0, halted}, 32'h0);
      syscall = 1; v0_val = 32'd10;
      tick(); clr();
      chk("halt2.h", {31'b0, halted}, 32'h1);
      chk("halt2.cyc", cycle_cnt, 32'd25);
      repeat (5) tick();
      chk("held.pc", pc, 32'h44);
      chk("held.h", {31'b0, halted}, 32'h1);
      go = 0;
      repeat (2) tick();
      chk("rel.pc", pc, 32'h44);

      go = 1;
      tick();
      #3 rst_n = 0;
      #1;
      chk("arst.pc", pc, 32'h0);
      chk("arst.h", {31'b0, halted}, 32'h0);
      chk_cnt("arst", 0, 0, 0);
      tick();
      chk("arst.hold", pc, 32'h0);
      rst_n = 1;
      repeat (3) tick();
      chk("post.pc", pc, 32'hc);
      chk("post.cyc", cycle_cnt, 32'd3);
      syscall = 1; v0_val = 32'd10;
      tick(); clr();
      repeat (3) tick();
      chk("post.halt.pc", pc, 32'hc);
      chk("post.halt.h", {31'b0, halted}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
